mips_intr_ctrl: RTL
===================

// Module: mips_intr_ctrl
// PURPOSE
//  Interrupt controller upstream of the MCU: produces the MCU's intr input and consumes its int_ack.
//  Edge-detects NSRC external sources into a pending register, applies a software mask,
//  raises intr, and on int_ack latches the winning source number for the ISR.
//  Software reaches it over a small memory-mapped port decoded alongside data memory (dm_cs/dm_rd/dm_wr style).
// PARAMETERS
//  NSRC  8  number of interrupt sources (2..32)
//  VW    3  vector width, = clog2(NSRC)
// PORTS
//  sys_clk   in   1     system clock, all logic on rising edge
//  reset     in   1     synchronous, active-low reset (sampled on sys_clk rising edge)
//  irq_src   in   NSRC  raw level sources, already synchronous to sys_clk
//  int_ack   in   1     MCU acknowledge of intr
//  intr      out  1     interrupt request to MCU (registered)
//  int_vec   out  VW    source number of last acknowledged interrupt
//  ic_cs     in   1     register-port chip select
//  ic_rd     in   1     read strobe (valid with ic_cs)
//  ic_wr     in   1     write strobe (valid with ic_cs)
//  ic_addr   in   2     register select: 0 PEND, 1 MASK, 2 VECTOR, 3 STATUS
//  ic_din    in   32    write data
//  ic_dout   out  32    read data (registered)
// BEHAVIOUR
//  Reset (reset==0 at edge): pend, mask, prev_src, int_vec, ic_dout = 0; intr=0; state=IDLE.
//  Edge detect: prev_src <= irq_src each cycle; pend[i] set when irq_src[i] & ~prev_src[i].
//  Registers: PEND RO, write-1-to-clear; MASK RW (1=enabled); VECTOR RO {0,int_vec};
//   STATUS read {29'b0, state[1:0], intr}; STATUS write with ic_din[0]=1 is EOI.
//  Simultaneous pend set (new edge) and clear (W1C or ack) on same bit: set wins.
//  Read: ic_cs&ic_rd at edge N -> ic_dout valid after edge N (1-cycle latency); else ic_dout=0.
//  Writes take effect at the edge they are sampled; ic_rd&ic_wr together: write done, read returns pre-write value.
//  active = pend & mask; winner = lowest index i with active[i] (fixed priority, bit 0 highest).
//  FSM (2-bit): IDLE=0, REQ=1, SERVICE=2; 3 unused -> IDLE.
//   IDLE:    |active -> REQ, intr<=1 (intr rises 1 edge after active goes nonzero).
//   REQ:     intr held 1. int_ack=1 -> int_vec<=winner, pend[winner]<=0, intr<=0, -> SERVICE.
//            active becomes 0 (masked/cleared) before ack -> intr<=0, -> IDLE (request withdrawn).
//            winner evaluated at the ack edge, not at request time.
//   SERVICE: intr=0, no new request; pend keeps collecting. EOI write -> IDLE;
//            if active!=0 then, intr re-asserts one edge later (IDLE->REQ path).
//  int_ack outside REQ is ignored. EOI outside SERVICE is ignored.
//  Reset mid-operation (any state) returns all state to reset values next edge; pending edges discarded.
//  Source held high produces exactly one pend event; must drop and re-rise to re-pend.
// TESTING
//  T1 reset: reset=0 two cycles, irq_src=8'hFF -> intr=0, PEND=0, MASK=0; release, PEND reads 8'hFF but intr stays 0 (mask 0).
//  T2 basic: MASK=8'h04, pulse irq_src[2] -> intr=1 one edge after pend; int_ack 1 cycle -> intr=0,
//     VECTOR=2, PEND[2]=0, STATUS=3'b100 (SERVICE); EOI -> STATUS=0.
//  T3 priority: MASK=8'hFF, irq_src[5] and [3] rise together -> ack yields int_vec=3; EOI -> intr
//     re-asserts, second ack yields int_vec=5.
//  T4 withdrawal: MASK=8'h01, pend[0], intr=1; write MASK=0 before ack -> intr=0 next edge, state IDLE, PEND[0] still 1.
//  T5 set-vs-clear: W1C PEND bit 1 on same edge as new rising irq_src[1] -> PEND[1]=1 afterwards.
//  T6 reset in REQ and SERVICE: assert reset with intr=1 -> intr=0, int_vec=0, state IDLE next edge; ack during reset ignored.

Source files
------------

// File: rtl/mips_intr_ctrl_if.sv
// Purpose : register port and interrupt handshake between the MCU side and mips_intr_ctrl.
// Ports   : ic_cs/ic_rd/ic_wr/ic_addr/ic_din driven by master, ic_dout returned by slave;
//           int_ack driven by master, intr/int_vec driven by slave.
interface mips_intr_ctrl_if #(
   parameter int VW = 3
);
   logic          ic_cs;
   logic          ic_rd;
   logic          ic_wr;
   logic [1:0]    ic_addr;
   logic [31:0]   ic_din;
   logic [31:0]   ic_dout;
   logic          int_ack;
   logic          intr;
   logic [VW-1:0] int_vec;

   modport master (
      output ic_cs, ic_rd, ic_wr, ic_addr, ic_din, int_ack,
      input  ic_dout, intr, int_vec
   );

   modport slave (
      input  ic_cs, ic_rd, ic_wr, ic_addr, ic_din, int_ack,
      output ic_dout, intr, int_vec
   );
endinterface

// File: rtl/mips_intr_ctrl.sv
// Purpose : edge-detecting, maskable, fixed-priority interrupt controller feeding the MCU intr/int_ack pair.
// Latency : intr rises one edge after an enabled pend bit appears; register reads return one edge after the strobe.
// Ports   : sys_clk, reset (sync, active-low), irq_src[NSRC]; bus (slave) carries ic_* register port and intr/int_ack/int_vec.
module mips_intr_ctrl #(
   parameter int NSRC = 8,
   parameter int VW   = 3
) (
   input  logic            sys_clk,
   input  logic            reset,
   input  logic [NSRC-1:0] irq_src,
   mips_intr_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   localparam logic [1:0] A_PEND   = 2'd0;
   localparam logic [1:0] A_MASK   = 2'd1;
   localparam logic [1:0] A_VECTOR = 2'd2;
   localparam logic [1:0] A_STATUS = 2'd3;

   state_t          state;
   state_t          state_nxt;
   logic [NSRC-1:0] pend;
   logic [NSRC-1:0] pend_nxt;
   logic [NSRC-1:0] mask;
   logic [NSRC-1:0] prev_src;
   logic            intr_q;
   logic            intr_d;
   logic [VW-1:0]   int_vec_q;
   logic [31:0]     dout_q;

   logic [NSRC-1:0] rise;
   logic [NSRC-1:0] active;
   logic            any_active;
   logic [VW-1:0]   winner;
   logic            wr_en;
   logic            rd_en;
   logic            eoi;
   logic            ack_take;
   logic [NSRC-1:0] w1c_clr;
   logic [NSRC-1:0] ack_clr;
   logic [31:0]     rdata;

   // Upper write-data bits are meaningless for a narrow NSRC; fold them away.
   logic            unused_din;
   assign unused_din = ^bus.ic_din;

   assign rise       = irq_src & ~prev_src;
   assign active     = pend & mask;
   assign any_active = |active;
   assign wr_en      = bus.ic_cs & bus.ic_wr;
   assign rd_en      = bus.ic_cs & bus.ic_rd;
   assign eoi        = wr_en && (bus.ic_addr == A_STATUS) && bus.ic_din[0];

   // Scan from the top so the lowest active index is the last one written.
   always_comb begin
      winner = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (active[i]) winner = VW'(i);
      end
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge sys_clk) begin
      if (!reset) begin
         state  <= IDLE;
         intr_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         intr_q <= intr_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE:    state_nxt = any_active ? REQ : IDLE;
         // Withdrawal takes precedence: an ack with nothing active has no winner to hand out.
         REQ:     state_nxt = !any_active ? IDLE : (bus.int_ack ? SERVICE : REQ);
         SERVICE: state_nxt = eoi ? IDLE : SERVICE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      intr_d   = (state_nxt == REQ);
      ack_take = (state == REQ) && bus.int_ack && any_active;
      ack_clr  = ack_take ? (NSRC'(1) << winner) : '0;
   end

   // A new edge on the same bit beats any clear in the same cycle.
   always_comb begin
      w1c_clr  = (wr_en && (bus.ic_addr == A_PEND)) ? bus.ic_din[NSRC-1:0] : '0;
      pend_nxt = (pend & ~w1c_clr & ~ack_clr) | rise;
   end

   // Read mux sees pre-write values, so a combined read+write returns the old contents.
   always_comb begin
      rdata = '0;
      case (bus.ic_addr)
         A_PEND:   rdata[NSRC-1:0] = pend;
         A_MASK:   rdata[NSRC-1:0] = mask;
         A_VECTOR: rdata[VW-1:0]   = int_vec_q;
         default:  rdata = {29'b0, state, intr_q};
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!reset) begin
         pend      <= '0;
         mask      <= '0;
         prev_src  <= '0;
         int_vec_q <= '0;
         dout_q    <= '0;
      end else begin
         prev_src <= irq_src;
         pend     <= pend_nxt;
         if (wr_en && (bus.ic_addr == A_MASK)) mask <= bus.ic_din[NSRC-1:0];
         if (ack_take) int_vec_q <= winner;
         dout_q <= rd_en ? rdata : 32'd0;
      end
   end

   assign bus.intr    = intr_q;
   assign bus.int_vec = int_vec_q;
   assign bus.ic_dout = dout_q;

endmodule
